// File: rtl/stopwatch_mmss.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_mmss
//  Description : MM:SS stopwatch driven by the 1 Hz divider output. Samples
//                the divided clock and the pushbuttons as data, edge-detects
//                them into one-cycle events and counts in BCD 00:00..59:59
//                with IDLE/RUN/PAUSE control and active-low 7-seg outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_mmss (
    input  logic       speed_clock,
    input  logic       reset,
    input  logic       low_clock,
    input  logic       key_start,
    input  logic       key_clear,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       running,
    output logic       wrap
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // r_valid marks when the second synchroniser stage holds real sampled
    // data rather than its reset preload. Each input is "armed" only once
    // its idle level has been really observed, so an input already in its
    // active level across reset release never produces an event.
    logic [1:0] r_valid;
    logic [1:0] r_lc_sync, r_ks_sync, r_kc_sync;
    logic       r_lc_prev, r_ks_prev, r_kc_prev;
    logic       r_lc_armed, r_ks_armed, r_kc_armed;
    logic       r_tick, r_start_p, r_clear_p;

    logic [1:0] r_state;
    logic [3:0] r_su;
    logic [2:0] r_st;
    logic [3:0] r_mu;
    logic [2:0] r_mt;
    logic       r_wrap;

    // Synchronise inputs, keep previous value and register one-cycle events
    always_ff @(posedge speed_clock) begin
        if (!reset) begin
            r_valid    <= 2'b00;
            r_lc_sync  <= 2'b00;
            r_lc_prev  <= 1'b0;
            r_ks_sync  <= 2'b11;
            r_ks_prev  <= 1'b1;
            r_kc_sync  <= 2'b11;
            r_kc_prev  <= 1'b1;
            r_lc_armed <= 1'b0;
            r_ks_armed <= 1'b0;
            r_kc_armed <= 1'b0;
            r_tick     <= 1'b0;
            r_start_p  <= 1'b0;
            r_clear_p  <= 1'b0;
        end else begin
            r_valid    <= {r_valid[0], 1'b1};
            r_lc_sync  <= {r_lc_sync[0], low_clock};
            r_ks_sync  <= {r_ks_sync[0], key_start};
            r_kc_sync  <= {r_kc_sync[0], key_clear};
            r_lc_prev  <= r_lc_sync[1];
            r_ks_prev  <= r_ks_sync[1];
            r_kc_prev  <= r_kc_sync[1];
            r_lc_armed <= r_lc_armed | (r_valid[1] & ~r_lc_sync[1]);
            r_ks_armed <= r_ks_armed | (r_valid[1] &  r_ks_sync[1]);
            r_kc_armed <= r_kc_armed | (r_valid[1] &  r_kc_sync[1]);
            r_tick     <= r_lc_armed & ~r_lc_prev &  r_lc_sync[1];
            r_start_p  <= r_ks_armed &  r_ks_prev & ~r_ks_sync[1];
            r_clear_p  <= r_kc_armed &  r_kc_prev & ~r_kc_sync[1];
        end
    end

    // Control FSM and BCD counter; tick uses the pre-transition state, clear wins
    always_ff @(posedge speed_clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_su    <= 4'd0;
            r_st    <= 3'd0;
            r_mu    <= 4'd0;
            r_mt    <= 3'd0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (r_clear_p) begin
                r_state <= ST_IDLE;
                r_su    <= 4'd0;
                r_st    <= 3'd0;
                r_mu    <= 4'd0;
                r_mt    <= 3'd0;
            end else begin
                if (r_state == ST_RUN && r_tick) begin
                    if (r_su == 4'd9) begin
                        r_su <= 4'd0;
                        if (r_st == 3'd5) begin
                            r_st <= 3'd0;
                            if (r_mu == 4'd9) begin
                                r_mu <= 4'd0;
                                if (r_mt == 3'd5) begin
                                    r_mt   <= 3'd0;
                                    r_wrap <= 1'b1;
                                end else begin
                                    r_mt <= r_mt + 3'd1;
                                end
                            end else begin
                                r_mu <= r_mu + 4'd1;
                            end
                        end else begin
                            r_st <= r_st + 3'd1;
                        end
                    end else begin
                        r_su <= r_su + 4'd1;
                    end
                end
                if (r_start_p) begin
                    case (r_state)
                        ST_IDLE:  r_state <= ST_RUN;
                        ST_RUN:   r_state <= ST_PAUSE;
                        ST_PAUSE: r_state <= ST_RUN;
                        default:  r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Active-low segment decode, bit6=g .. bit0=a; blank for non-BCD codes
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Displays and status decoded from registered state
    always_comb begin
        hex0    = seg7(r_su);
        hex1    = seg7({1'b0, r_st});
        hex2    = seg7(r_mu);
        hex3    = seg7({1'b0, r_mt});
        running = (r_state == ST_RUN);
        wrap    = r_wrap;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_mmss.md
# stopwatch_mmss

Minutes:seconds stopwatch that consumes the 1 Hz square wave produced by the frequency divider and displays elapsed time on four active-low seven-segment digits. It runs entirely in the fast board-clock domain. It samples the divided clock as data, edge-detects it into a one-cycle tick, and counts ticks in BCD from 00:00 to 59:59 under start/stop and clear pushbutton control. It sits directly downstream of the divider and drives the HEX3..HEX0 display pins.

## Interface
- `speed_clock` in 1: board clock (50 MHz); all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on `speed_clock` rising edge.
- `low_clock` in 1: divided clock from the divider; treated as asynchronous data.
- `key_start` in 1: start/stop pushbutton; active-low; already debounced upstream.
- `key_clear` in 1: clear pushbutton; active-low; already debounced.
- `hex0` out 7: seconds units; active-low segments; bit6=g … bit0=a.
- `hex1` out 7: seconds tens.
- `hex2` out 7: minutes units.
- `hex3` out 7: minutes tens.
- `running` out 1: high while in RUN.
- `wrap` out 1: one-cycle pulse when the count rolls 59:59 → 00:00.

## Operation
- **Input synchronisation**
  - `low_clock`, `key_start` and `key_clear` each pass through a 2-flop synchroniser.
  - A third register holds the previous synced value for edge detection.
- **Event pulses** (each is one cycle wide)
  - `tick`: synced `low_clock` rising edge (0→1).
  - `start_p`: synced `key_start` falling edge (press).
  - `clear_p`: synced `key_clear` falling edge (press).
- **FSM states:** IDLE, RUN, PAUSE.
  - IDLE: count frozen at 00:00. `start_p` → RUN.
  - RUN: `tick` increments the count. `start_p` → PAUSE. `clear_p` → IDLE with count zeroed.
  - PAUSE: count held. `start_p` → RUN. `clear_p` → IDLE with count zeroed.
- **Priority within one cycle:** `clear_p` > `start_p`.
  - A `tick` in RUN is always applied using the pre-transition state. So `tick`+`start_p` in RUN increments and then enters PAUSE.
  - `tick`+`clear_p` in RUN: clear wins; count = 00:00, no increment.
- **Counting:** four BCD digits, `su` 4b (0-9), `st` 3b (0-5), `mu` 4b (0-9), `mt` 3b (0-5).
  - `su` 9→0 carries into `st`; `st` 5→0 carries into `mu`; `mu` 9→0 carries into `mt`.
  - At 59:59, a tick gives 00:00, asserts `wrap` for that cycle, and the FSM stays in RUN.
- **Digit values:** illegal values are unreachable. The decoder outputs blank (1111111) for any non-BCD value.
- **Seven-segment encoding** (active-low), combinational from the registered digits:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

## Timing
- **Reset** (`reset`=0 at a rising edge), overriding all other inputs:
  - FSM returns to IDLE and the count to 00:00.
  - `low_clock` synchroniser/edge flops are loaded with 0; key flops are loaded with 1 (released).
  - `running`=0, `wrap`=0, `hex3..hex0`=1000000.
  - Reset mid-count discards the count, and no spurious edge pulse fires on release.
- **Input-to-event latency:** 3 `speed_clock` edges from the first edge at which an input change is sampled to its event pulse being high. The count, FSM and `running` update on the next edge, so displays change 4 edges after the input change.
- **`wrap`:** high exactly during the cycle in which the count register holds 00:00 after rollover; it is registered.
- **Level inputs:** a held-low key produces exactly one `start_p`/`clear_p`. A `low_clock` high phase produces exactly one `tick`.
- **Minimum pulse width:** an input high or low for less than 1 `speed_clock` period may be missed. This is acceptable and not specified.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `low_clock` toggling → all hex = 1000000, `running`=0, `wrap`=0. Release; no tick counted until the next `low_clock` rise.
- **Start and count:** press `key_start`, then apply 12 `low_clock` rises (fast period, e.g. 20 cycles, in bench) → `running`=1, display 00:12 (`hex1`=1111001, `hex0`=0100100). Check exact 4-edge latency on the first tick.
- **Pause/resume:**
  - At 00:05, press start → `running`=0.
  - 10 further ticks → display stays 00:05.
  - Press start and give 1 tick → 00:06.
- **Rollover:** preload by running 3599 ticks → 59:59. One more tick → 00:00, `wrap` high for exactly 1 cycle, `running` still 1.
- **Simultaneous events:**
  - Align the `clear` and `tick` edges in RUN at 00:30 → 00:00, state IDLE, `running`=0.
  - Align the `start` and `tick` edges in RUN at 00:30 → 00:31 and PAUSE.
- **Reset mid-operation:** at 12:34 in RUN, assert `reset` for 1 cycle → next cycle 00:00, IDLE. Holding `key_start` low through reset release produces no start event.
